// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage RV32 pipeline.
//   XLEN_DEF / ILEN_DEF : default address and instruction widths
//   NOP_INSTR           : canonical RV32 NOP (addi x0, x0, 0)
//   PC_STEP             : sequential fetch increment in bytes
//   fetch_state_t       : fetch-stage FSM states
//   sat_inc             : saturating 32-bit increment for event counters
package pipeline_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/if_stage_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
//   imem_req   : request valid (fetch side)
//   imem_addr  : fetch address (fetch side)
//   imem_rdata : instruction returned (memory side)
//   imem_ready : imem_rdata is valid for imem_addr this cycle (memory side)
// Modports: master = fetch stage, slave = instruction memory.
interface if_stage_fetch_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset        : clock and synchronous active-high reset
//   load              : capture pc_in/instr_in as a valid instruction
//   flush             : insert a bubble (pc 0, NOP, valid 0)
//   pc_in, instr_in   : fetched PC and instruction
//   pc, instr, valid  : registered IF/ID fields
// With neither load nor flush the register holds its contents.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [ILEN-1:0] instr_in,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr,
  output logic            valid
);

  // Flush wins over load so a redirect can never let a wrong-path instruction in.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc    <= '0;
      instr <= ILEN'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// fills the IF/ID register.
//   clk, reset          : clock, synchronous active-high reset
//   pc_write, if_write  : hazard-unit enables; either low holds PC and IF/ID
//   branch_taken        : EX redirect; flushes IF/ID and reloads the PC
//   branch_target       : redirect address (low two bits ignored)
//   imem                : instruction-memory bus (master side)
//   if_id_pc/instr/valid: IF/ID register contents
//   fetch_stall         : fetching but memory not ready this cycle
// Optional macro IF_PERF_COUNTERS_EN adds saturating counters
//   perf_stall_cnt (hazard holds), perf_flush_cnt (redirects),
//   perf_bubble_cnt (memory waits).
module if_stage_fetch
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             if_write,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  if_stage_fetch_if.master imem,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [ILEN-1:0]  if_id_instr,
  output logic             if_id_valid,
  output logic             fetch_stall
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            hold, wait_mem, load_id, flush_id;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];

  // FSM state register: boot for one cycle after reset, then fetch forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state and PC/IF-ID control, in priority order branch > hold > wait > advance.
  // The boot cycle has no memory response, so it inserts a bubble like a wait.
  always_comb begin
    state_next = S_FETCH;
    pc_next    = pc;
    load_id    = 1'b0;
    flush_id   = 1'b0;
    hold       = ~pc_write | ~if_write;
    wait_mem   = (state == S_FETCH) & ~imem.imem_ready;
    if (branch_taken) begin
      pc_next  = {branch_target[XLEN-1:2], 2'b00};
      flush_id = 1'b1;
    end else if (hold) begin
      pc_next = pc;
    end else if ((state == S_FETCH) && imem.imem_ready) begin
      pc_next = pc + XLEN'(PC_STEP);
      load_id = 1'b1;
    end else begin
      flush_id = 1'b1;
    end
  end

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign fetch_stall    = wait_mem;

  if_id_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_id),
    .flush    (flush_id),
    .pc_in    (pc),
    .instr_in (imem.imem_rdata),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef IF_PERF_COUNTERS_EN
  // Event counters follow the same priority as the datapath so each cycle is
  // attributed to at most one cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (branch_taken)
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      if (!branch_taken && hold)
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (!branch_taken && !hold && wait_mem)
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking testbench for if_stage_fetch (RESET_PC = 0x100).
// A behavioural model tracks PC, IF/ID and a boot flag from the priority
// rules; instruction memory is a fixed function of the address.
module tb_if_stage_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, pc_write, if_write, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid, fetch_stall;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_id_pc, m_id_instr;
  logic        m_id_valid, m_boot;
  logic [31:0] m_stall, m_flush, m_bubble;

  if_stage_fetch_if #(.XLEN(32), .ILEN(32)) imem ();

  if_stage_fetch #(.XLEN(32), .ILEN(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_write      (if_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_stall   (fetch_stall)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Behavioural reference for one rising edge, from the current inputs.
  task automatic model_edge();
    if (reset) begin
      m_pc = RST_PC; m_boot = 1'b1;
      m_id_pc = 0; m_id_instr = NOP; m_id_valid = 1'b0;
      m_stall = 0; m_flush = 0; m_bubble = 0;
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC; m_boot = 1'b0;
      m_id_pc = 0; m_id_instr = NOP; m_id_valid = 1'b0;
      m_flush = sat(m_flush);
    end else if (!pc_write || !if_write) begin
      m_boot = 1'b0;
      m_stall = sat(m_stall);
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_id_pc = 0; m_id_instr = NOP; m_id_valid = 1'b0;
    end else if (!imem.imem_ready) begin
      m_id_pc = 0; m_id_instr = NOP; m_id_valid = 1'b0;
      m_bubble = sat(m_bubble);
    end else begin
      m_id_pc = m_pc; m_id_instr = imem.imem_rdata; m_id_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Advance one cycle; sample 1ns after the edge, then present memory data for the new PC.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    imem.imem_rdata = mem_word(m_pc);
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_write = 1'b1; if_write = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'h0;
    tick(); tick();
    n_cmp++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imem.imem_req); end
    n_cmp++; if (imem.imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", imem.imem_addr, RST_PC); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== NOP) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected %h", if_id_instr, NOP); end
    n_cmp++; if (if_id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_if_id_pc: got %h expected 0", if_id_pc); end
    n_cmp++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", fetch_stall); end
`ifdef IF_PERF_COUNTERS_EN
    n_cmp++; if ((perf_stall_cnt | perf_flush_cnt | perf_bubble_cnt) !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_counters: got %h/%h/%h expected 0", perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_startup_sequence();
    tick();
    n_cmp++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL boot_exit_req: got %b expected 1", imem.imem_req); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_bubble: got %b expected 0", if_id_valid); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (if_id_pc !== RST_PC + 32'(4 * k)) begin n_fail++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", k, if_id_pc, RST_PC + 32'(4 * k)); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid%0d: got %b expected 1", k, if_id_valid); end
      n_cmp++; if (if_id_instr !== mem_word(RST_PC + 32'(4 * k))) begin n_fail++; $display("[TB] FAIL seq_instr%0d: got %h expected %h", k, if_id_instr, mem_word(RST_PC + 32'(4 * k))); end
    end
  endtask

  task automatic test_hazard_hold();
    pc_write = 1'b0; if_write = 1'b0;
    tick();
    n_cmp++; if (imem.imem_addr !== 32'h108) begin n_fail++; $display("[TB] FAIL hold_pc: got %h expected 108", imem.imem_addr); end
    n_cmp++; if (if_id_pc !== 32'h104) begin n_fail++; $display("[TB] FAIL hold_if_id_pc: got %h expected 104", if_id_pc); end
    n_cmp++; if (if_id_instr !== mem_word(32'h104)) begin n_fail++; $display("[TB] FAIL hold_instr: got %h expected %h", if_id_instr, mem_word(32'h104)); end
    n_cmp++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_req: got %b expected 1", imem.imem_req); end
    pc_write = 1'b1; if_write = 1'b1;
    tick();
    n_cmp++; if (if_id_pc !== 32'h108) begin n_fail++; $display("[TB] FAIL hold_release: got %h expected 108", if_id_pc); end
    pc_write = 1'b1; if_write = 1'b0;
    tick();
    n_cmp++; if (imem.imem_addr !== 32'h10C || if_id_pc !== 32'h108) begin n_fail++; $display("[TB] FAIL if_write_only_hold: got pc %h id %h expected 10c/108", imem.imem_addr, if_id_pc); end
    if_write = 1'b1;
  endtask

  task automatic test_branch_during_hold();
    branch_taken = 1'b1; branch_target = 32'h203; pc_write = 1'b0;
    tick();
    n_cmp++; if (imem.imem_addr !== 32'h200) begin n_fail++; $display("[TB] FAIL branch_pc: got %h expected 200", imem.imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL branch_flush: got %b/%h/%h expected 0/00000013/0", if_id_valid, if_id_instr, if_id_pc); end
    branch_taken = 1'b0; pc_write = 1'b1;
    tick();
    n_cmp++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL branch_refetch: got %h/%b expected 200/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_memory_wait();
    imem.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_stall%0d: got %b expected 1", k, fetch_stall); end
      n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_fail++; $display("[TB] FAIL wait_bubble%0d: got %b/%h expected 0/00000013", k, if_id_valid, if_id_instr); end
      n_cmp++; if (imem.imem_addr !== 32'h204) begin n_fail++; $display("[TB] FAIL wait_pc%0d: got %h expected 204", k, imem.imem_addr); end
    end
    imem.imem_ready = 1'b1;
    #1;
    n_cmp++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_stall_clear: got %b expected 0", fetch_stall); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h204 || if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_resume: got %h/%b expected 204/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (imem.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_setup: got %h expected fffffffc", imem.imem_addr); end
    tick();
    n_cmp++; if (imem.imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 0", imem.imem_addr); end
    n_cmp++; if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_if_id_pc: got %h expected fffffffc", if_id_pc); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    imem.imem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_req: got %b expected 0", imem.imem_req); end
    n_cmp++; if (imem.imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL midreset_pc: got %h expected %h", imem.imem_addr, RST_PC); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_fail++; $display("[TB] FAIL midreset_if_id: got %b/%h expected 0/00000013", if_id_valid, if_id_instr); end
`ifdef IF_PERF_COUNTERS_EN
    n_cmp++; if ((perf_stall_cnt | perf_flush_cnt | perf_bubble_cnt) !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_counters: got %h/%h/%h expected 0", perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt); end
`endif
    reset = 1'b0; imem.imem_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      pc_write      = ($urandom_range(0, 5) != 0);
      if_write      = ($urandom_range(0, 5) != 0);
      imem.imem_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++; if (imem.imem_addr !== m_pc) begin n_fail++; $display("[TB] FAIL rand_pc cyc %0d: got %h expected %h", i, imem.imem_addr, m_pc); end
      n_cmp++; if (imem.imem_req !== !m_boot) begin n_fail++; $display("[TB] FAIL rand_req cyc %0d: got %b expected %b", i, imem.imem_req, !m_boot); end
      n_cmp++; if (if_id_pc !== m_id_pc) begin n_fail++; $display("[TB] FAIL rand_if_id_pc cyc %0d: got %h expected %h", i, if_id_pc, m_id_pc); end
      n_cmp++; if (if_id_instr !== m_id_instr) begin n_fail++; $display("[TB] FAIL rand_instr cyc %0d: got %h expected %h", i, if_id_instr, m_id_instr); end
      n_cmp++; if (if_id_valid !== m_id_valid) begin n_fail++; $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", i, if_id_valid, m_id_valid); end
      n_cmp++; if (fetch_stall !== (!m_boot && !imem.imem_ready)) begin n_fail++; $display("[TB] FAIL rand_stall cyc %0d: got %b expected %b", i, fetch_stall, (!m_boot && !imem.imem_ready)); end
`ifdef IF_PERF_COUNTERS_EN
      n_cmp++; if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush || perf_bubble_cnt !== m_bubble) begin n_fail++; $display("[TB] FAIL rand_counters cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt, m_stall, m_flush, m_bubble); end
`endif
    end
  endtask

  initial begin
    $display("[TB] if_stage_fetch bench start");
    test_reset();
    test_startup_sequence();
    test_hazard_hold();
    test_branch_during_hold();
    test_memory_wait();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32 pipeline.
- Owns the PC and drives the instruction-memory request.
- Consumes pc_write / if_write from the hazard detection unit and the branch redirect from EX.
- Produces the IF/ID fields (pc, instr, valid) that ID decodes and that feed the hazard unit's rs1/rs2 comparison.

Parameters:
- XLEN, 32, PC and address width.
- ILEN, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_write  in  1  from hazard unit; 0 = hold PC.
- if_write  in  1  from hazard unit; 0 = hold IF/ID.
- branch_taken  in  1  EX-stage redirect request.
- branch_target  in  XLEN  redirect address.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  XLEN  fetch address (always equals the PC register).
- imem_rdata  in  ILEN  instruction returned.
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr.
- if_id_pc  out  XLEN  PC of the instruction held in IF/ID.
- if_id_instr  out  ILEN  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_stall  out  1  fetch waiting on memory (combinational).

Behaviour:
- FSM states:
  - S_BOOT: entered on reset; imem_req=0; unconditionally goes to S_FETCH next cycle.
  - S_FETCH: imem_req=1. Stays in S_FETCH except on reset.
- Reset values: pc=RESET_PC, state=S_BOOT, if_id_pc=0, if_id_instr=NOP (32'h0000_0013), if_id_valid=0. Reset mid-fetch discards any pending response.
- Per-cycle priority: reset > branch_taken > hazard hold > memory wait > advance.
- branch_taken=1 (S_FETCH or S_BOOT):
  - pc <= {branch_target[XLEN-1:2],2'b00}.
  - IF/ID flushed: instr <= NOP, valid <= 0; if_id_pc <= 0.
  - Same-cycle imem response is discarded.
  - Overrides pc_write=0 and if_write=0.
- Hazard hold (pc_write=0 or if_write=0, no branch):
  - pc and all IF/ID fields hold.
  - imem_req stays 1; the response is discarded and re-fetched later (memory is idempotent).
  - pc_write and if_write are held together; if either is 0, both pc and IF/ID hold.
- Memory wait (S_FETCH, imem_ready=0, no hold, no branch):
  - pc holds; fetch_stall=1.
  - IF/ID <= bubble (instr NOP, valid 0).
- Advance (S_FETCH, imem_ready=1, pc_write=1, if_write=1, no branch):
  - if_id_pc <= pc; if_id_instr <= imem_rdata; if_id_valid <= 1.
  - pc <= pc + 4, modulo 2^XLEN (wraps from 32'hFFFF_FFFC to 0).
- fetch_stall = (state==S_FETCH) & ~imem_ready.
- Latency: instruction reaches IF/ID one cycle after the imem_ready cycle. Sustains 1 instr/cycle with imem_ready held high.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- Defined: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0], perf_bubble_cnt[31:0].
  - perf_stall_cnt counts hazard-hold cycles; perf_flush_cnt counts branch_taken cycles; perf_bubble_cnt counts memory-wait cycles.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

Decomposition:
- Shared package pipeline_pkg:
  - XLEN/ILEN defaults.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
  - fetch-state enum {S_BOOT, S_FETCH}.
- Sub-module if_id_reg: IF/ID register with load, flush (NOP/valid 0), hold; instantiated once. PC and FSM stay in the top module.

Test Plan:
- Reset release, RESET_PC=0x100, imem_ready=1 -> cycle 1 imem_req=0; then if_id_pc sequence 0x100, 0x104, 0x108 with if_id_valid=1 each cycle.
- Hazard hold: pc_write=if_write=0 for 1 cycle at pc=0x108 -> pc stays 0x108, IF/ID holds 0x104 instr; 0x108 loads next cycle.
- Branch during hold: branch_taken=1, target=0x203, pc_write=0 -> pc=0x200, if_id_valid=0, if_id_instr=0x13; next fetch address 0x200.
- Memory wait: imem_ready=0 for 3 cycles -> fetch_stall=1, three bubbles (valid 0, NOP), pc unchanged; resumes on ready.
- Wrap: pc=0xFFFF_FFFC, advance -> pc=0x0000_0000.
- Reset asserted while imem_ready=0 in S_FETCH -> next cycle state S_BOOT, pc=RESET_PC, IF/ID NOP/valid 0. With IF_PERF_COUNTERS_EN, all counters read 0.
